perf_counter_bank: RTL and testbench

- Synthesizable, parametrised performance-counter bank for the rasterizer pipeline; replaces testbench-only counting with hardware counters.
- Takes NUM_EVT event strobes (e.g. valid sample, sample hit, new triangle) and delays each by ALIGN_DEPTH stages to match pipe latency.
- Counts each strobe in level or edge mode alongside a free-running cycle counter.
- Snapshots all counters on request or periodically, then streams the snapshot out over a valid/ready port.

---
 rtl/perf_pkg.sv | 25 ++
 rtl/perf_evt_chan.sv | 95 +++++++++
 rtl/perf_counter_bank.sv | 224 ++++++++++++++++++++++
 tb/tb_perf_counter_bank.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// ---------------------------------------------------------------------------
// perf_pkg
// Shared types and constants for the rasterizer performance-counter bank.
//   perf_state_e : snapshot streamer state (IDLE / STREAM)
//   MODE_*       : per-channel counting mode encoding of cfg_edge bits
//   OVF_*        : per-slot overflow behaviour encoding of cfg_sat bits
//   slot_w(n)    : width of a slot index covering the cycle slot plus n events
// ---------------------------------------------------------------------------
package perf_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } perf_state_e;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;
    localparam logic OVF_WRAP   = 1'b0;
    localparam logic OVF_SAT    = 1'b1;

    function automatic int slot_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/perf_evt_chan.sv
// ---------------------------------------------------------------------------
// perf_evt_chan
// One event channel of the performance-counter bank: aligns the raw strobe
// to pipeline latency, optionally turns it into a rising-edge pulse, and
// counts it with saturating or wrapping overflow plus a sticky overflow flag.
//
// Ports
//   clk        : clock
//   rst        : asynchronous active-low reset
//   i_cfg_en   : counting enable (align pipe and edge history keep running)
//   i_cfg_edge : 1 = count rising edges, 0 = count high cycles
//   i_cfg_sat  : 1 = saturate at all-ones, 0 = wrap to zero
//   i_clear    : synchronous clear of counter and overflow flag
//   i_evt      : raw event strobe
//   o_cnt      : live counter value
//   o_ovf      : sticky overflow flag
// ---------------------------------------------------------------------------
module perf_evt_chan
    import perf_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int ALIGN_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cfg_en,
    input  logic             i_cfg_edge,
    input  logic             i_cfg_sat,
    input  logic             i_clear,
    input  logic             i_evt,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);

    logic             w_aevt;
    logic             w_inc;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    generate
        if (ALIGN_DEPTH == 0) begin : g_no_align
            assign w_aevt = i_evt;
        end else begin : g_align
            logic [ALIGN_DEPTH-1:0] r_pipe;

            // Plain shift register; deliberately ignores clear and cfg_en so
            // the alignment never loses or duplicates an in-flight strobe.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe[0] <= i_evt;
                    for (int i = 1; i < ALIGN_DEPTH; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_aevt = r_pipe[ALIGN_DEPTH-1];
        end
    endgenerate

    assign w_inc = i_cfg_en &
                   ((i_cfg_edge == MODE_EDGE) ? (w_aevt & ~r_prev) : w_aevt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            // Edge history tracks the aligned strobe every cycle, so a level
            // that rose while counting was disabled is not seen as a new edge.
            r_prev <= w_aevt;
            if (i_clear) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_inc) begin
                if (&r_cnt) begin
                    r_ovf <= 1'b1;
                    if (i_cfg_sat != OVF_SAT) begin
                        r_cnt <= '0;
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// ---------------------------------------------------------------------------
// perf_counter_bank
// Performance-counter bank for the rasterizer pipeline. Slot 0 is a
// free-running cycle counter, slots 1..NUM_EVT count aligned event strobes.
// A snapshot (on request or from the period timer) copies every live slot
// into shadow registers, which are then streamed out one slot per handshake.
//
// Ports
//   clk        : clock
//   rst        : asynchronous active-low reset
//   cfg_en     : counting enable for all counters and the period timer
//   cfg_edge   : per-channel mode, 1 = rising edges, 0 = high cycles
//   cfg_sat    : per-slot overflow mode, 1 = saturate, 0 = wrap (bit 0 = cycles)
//   clear      : synchronous clear of live counters, ovf, snap_drop, timer
//   evt        : raw event strobes
//   snap_req   : single-cycle snapshot request
//   out_valid  : stream word valid
//   out_ready  : consumer ready
//   out_idx    : slot index of the current word (0 = cycles, k = evt[k-1])
//   out_data   : shadowed counter value
//   out_last   : high on the final slot
//   ovf        : sticky overflow flag per live slot
//   snap_drop  : sticky, a trigger arrived while a stream was busy
// ---------------------------------------------------------------------------
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_EVT       = 4,
    parameter int CNT_W         = 32,
    parameter int ALIGN_DEPTH   = 3,
    parameter int REPORT_PERIOD = 100000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_en,
    input  logic [NUM_EVT-1:0]           cfg_edge,
    input  logic [NUM_EVT:0]             cfg_sat,
    input  logic                         clear,
    input  logic [NUM_EVT-1:0]           evt,
    input  logic                         snap_req,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [slot_w(NUM_EVT)-1:0]   out_idx,
    output logic [CNT_W-1:0]             out_data,
    output logic                         out_last,
    output logic [NUM_EVT:0]             ovf,
    output logic                         snap_drop
);

    localparam int                IDX_W    = slot_w(NUM_EVT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVT);

    logic [NUM_EVT:0][CNT_W-1:0] w_live;
    logic [NUM_EVT:0]            w_ovf;
    logic [NUM_EVT:0][CNT_W-1:0] r_shadow;

    logic [CNT_W-1:0] r_cyc_cnt;
    logic             r_cyc_ovf;
    logic             w_auto_trig;
    logic             w_trig;
    logic             w_hs;
    logic             w_capture;
    logic             w_drop_set;
    logic             r_snap_drop;

    perf_state_e      r_state;
    perf_state_e      w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;

    // ---------------- cycle counter (slot 0) ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc_cnt <= '0;
            r_cyc_ovf <= 1'b0;
        end else if (clear) begin
            r_cyc_cnt <= '0;
            r_cyc_ovf <= 1'b0;
        end else if (cfg_en) begin
            if (&r_cyc_cnt) begin
                r_cyc_ovf <= 1'b1;
                if (cfg_sat[0] == OVF_WRAP) begin
                    r_cyc_cnt <= '0;
                end
            end else begin
                r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            end
        end
    end

    assign w_live[0] = r_cyc_cnt;
    assign w_ovf[0]  = r_cyc_ovf;

    // ---------------- event channels (slots 1..NUM_EVT) ----------------
    generate
        for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_chan
            perf_evt_chan #(
                .CNT_W       (CNT_W),
                .ALIGN_DEPTH (ALIGN_DEPTH)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .i_cfg_en   (cfg_en),
                .i_cfg_edge (cfg_edge[gi]),
                .i_cfg_sat  (cfg_sat[gi+1]),
                .i_clear    (clear),
                .i_evt      (evt[gi]),
                .o_cnt      (w_live[gi+1]),
                .o_ovf      (w_ovf[gi+1])
            );
        end
    endgenerate

    // ---------------- period timer ----------------
    generate
        if (REPORT_PERIOD == 0) begin : g_no_period
            assign w_auto_trig = 1'b0;
        end else begin : g_period
            localparam int              PER_W   = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
            localparam logic [PER_W-1:0] PER_TOP = PER_W'(REPORT_PERIOD - 1);

            logic [PER_W-1:0] r_period;

            // Fires on the enabled cycle that completes a period, so the
            // captured cycle slot reads REPORT_PERIOD-1 after a fresh start.
            assign w_auto_trig = cfg_en & (r_period == PER_TOP);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_period <= '0;
                end else if (clear) begin
                    r_period <= '0;
                end else if (cfg_en) begin
                    if (r_period == PER_TOP) begin
                        r_period <= '0;
                    end else begin
                        r_period <= r_period + PER_W'(1);
                    end
                end
            end
        end
    endgenerate

    // ---------------- snapshot streamer ----------------
    assign w_trig = snap_req | w_auto_trig;
    assign w_hs   = (r_state == STREAM) & out_ready;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_capture    = 1'b0;
        w_drop_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_capture    = 1'b1;
                    w_state_next = STREAM;
                    w_idx_next   = '0;
                end
            end
            STREAM: begin
                if (w_hs && (r_idx == LAST_IDX)) begin
                    // A trigger landing on the final handshake is taken
                    // immediately so back-to-back reports have no bubble.
                    w_idx_next = '0;
                    if (w_trig) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    if (w_hs) begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                    if (w_trig) begin
                        w_drop_set = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Shadows take the registered live values, i.e. before this cycle's
    // increment or clear lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= '0;
        end else if (w_capture) begin
            r_shadow <= w_live;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap_drop <= 1'b0;
        end else if (clear) begin
            r_snap_drop <= 1'b0;
        end else if (w_drop_set) begin
            r_snap_drop <= 1'b1;
        end
    end

    assign out_valid = (r_state == STREAM);
    assign out_idx   = r_idx;
    assign out_data  = out_valid ? r_shadow[r_idx] : '0;
    assign out_last  = out_valid & (r_idx == LAST_IDX);
    assign ovf       = w_ovf;
    assign snap_drop = r_snap_drop;

endmodule

// File: tb/tb_perf_counter_bank.sv
`timescale 1ns/1ps
module tb_perf_counter_bank;

    localparam int NE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cfg_en;
    logic [NE-1:0] cfg_edge;
    logic [NE:0]   cfg_sat;
    logic          clear;
    logic [NE-1:0] evt;
    logic          snap_req;
    logic          out_ready;

    // dut_a: 32-bit counters, no auto report
    logic        a_valid, a_last, a_drop;
    logic [2:0]  a_idx;
    logic [31:0] a_data;
    logic [4:0]  a_ovf;
    // dut_s: 4-bit counters for overflow behaviour
    logic        s_valid, s_last, s_drop;
    logic [2:0]  s_idx;
    logic [3:0]  s_data;
    logic [4:0]  s_ovf;
    // dut_p: 16-bit counters, report every 8 enabled cycles
    logic        p_valid, p_last, p_drop;
    logic [2:0]  p_idx;
    logic [15:0] p_data;
    logic [4:0]  p_ovf;

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(32), .ALIGN_DEPTH(3), .REPORT_PERIOD(0)) dut_a (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_edge(cfg_edge), .cfg_sat(cfg_sat),
        .clear(clear), .evt(evt), .snap_req(snap_req), .out_valid(a_valid),
        .out_ready(out_ready), .out_idx(a_idx), .out_data(a_data), .out_last(a_last),
        .ovf(a_ovf), .snap_drop(a_drop));

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(4), .ALIGN_DEPTH(3), .REPORT_PERIOD(0)) dut_s (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_edge(cfg_edge), .cfg_sat(cfg_sat),
        .clear(clear), .evt(evt), .snap_req(snap_req), .out_valid(s_valid),
        .out_ready(out_ready), .out_idx(s_idx), .out_data(s_data), .out_last(s_last),
        .ovf(s_ovf), .snap_drop(s_drop));

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(16), .ALIGN_DEPTH(3), .REPORT_PERIOD(8)) dut_p (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_edge(cfg_edge), .cfg_sat(cfg_sat),
        .clear(clear), .evt(evt), .snap_req(snap_req), .out_valid(p_valid),
        .out_ready(out_ready), .out_idx(p_idx), .out_data(p_data), .out_last(p_last),
        .ovf(p_ovf), .snap_drop(p_drop));

    // Selected DUT view used by the stream reader
    int          sel;
    logic        m_valid, m_last, m_drop;
    logic [2:0]  m_idx;
    logic [31:0] m_data;
    logic [4:0]  m_ovf;

    always_comb begin
        m_valid = a_valid; m_last = a_last; m_drop = a_drop;
        m_idx   = a_idx;   m_data = a_data; m_ovf  = a_ovf;
        if (sel == 1) begin
            m_valid = s_valid; m_last = s_last; m_drop = s_drop;
            m_idx   = s_idx;   m_data = {28'd0, s_data}; m_ovf = s_ovf;
        end else if (sel == 2) begin
            m_valid = p_valid; m_last = p_last; m_drop = p_drop;
            m_idx   = p_idx;   m_data = {16'd0, p_data}; m_ovf = p_ovf;
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          ncyc;      // enabled edges since reset release (model of slot 0)
    int          gcyc;      // all edges since reset release
    int          start_g;   // gcyc at which the last read stream became valid
    logic [31:0] sv [NE+1]; // words of the last read stream
    int          exp_cyc;
    int          pat [7] = '{1, 1, 0, 1, 0, 1, 1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        logic en;
        en = cfg_en;
        @(posedge clk);
        #1;
        gcyc++;
        if (en) ncyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0; snap_req = 1'b0; clear = 1'b0; evt = '0; out_ready = 1'b1;
        cfg_en = 1'b1;
        tick();
        tick();
        rst  = 1'b1;
        ncyc = 0;
        gcyc = 0;
    endtask

    task automatic pulse_snap();
        exp_cyc  = ncyc;
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    task automatic read_stream(input string tag);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!m_valid && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, {31'd0, m_valid}, 32'd1);
        start_g = gcyc;
        for (int i = 0; i <= NE; i++) begin
            chk($sformatf("%s_w%0d_vli", tag, i), {27'd0, m_valid, m_last, m_idx},
                {27'd0, 1'b1, (i == NE), 3'(i)});
            sv[i] = m_data;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; cfg_en = 1'b1; cfg_edge = '0; cfg_sat = '0; clear = 1'b0;
        evt = '0; snap_req = 1'b0; out_ready = 1'b1; rst = 1'b0;
        ncyc = 0; gcyc = 0; start_g = 0; exp_cyc = 0;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_valid_last_idx", {27'd0, a_valid, a_last, a_idx}, 32'd0);
        chk("rst_data", a_data, 32'd0);
        chk("rst_ovf_drop", {26'd0, a_ovf, a_drop}, 32'd0);

        // ---- 1: level count, alignment latency, basic stream ----
        do_reset();
        sel = 0;
        evt = 4'b0001;
        repeat (3) tick();
        chk("t1_lat_before", dut_a.g_chan[0].u_chan.r_cnt, 32'd0);
        tick();
        chk("t1_lat_first", dut_a.g_chan[0].u_chan.r_cnt, 32'd1);
        repeat (6) tick();
        evt = '0;
        while (ncyc < 20) tick();
        pulse_snap();
        read_stream("t1");
        chk("t1_cycles", sv[0], 32'd20);
        chk("t1_evt0", sv[1], 32'd10);
        chk("t1_evt1", sv[2], 32'd0);
        chk("t1_idle_after", {31'd0, a_valid}, 32'd0);

        // ---- 2: edge vs level on the same pattern ----
        do_reset();
        cfg_edge = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            evt = {1'b0, pat[i][0], pat[i][0], 1'b0};
            tick();
        end
        evt = '0;
        repeat (6) tick();
        pulse_snap();
        read_stream("t2");
        chk("t2_edge_cnt", sv[2], 32'd3);
        chk("t2_level_cnt", sv[3], 32'd5);
        chk("t2_idle_chan", sv[1], 32'd0);
        cfg_edge = '0;

        // ---- 3: 4-bit saturate vs wrap ----
        do_reset();
        sel = 1;
        cfg_sat = 5'b00010;
        evt = 4'b0011;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 18) chk("t3_ovf_after15", {30'd0, m_ovf[2:1]}, 32'd0);
            if (i == 19) chk("t3_ovf_after16", {30'd0, m_ovf[2:1]}, 32'd3);
        end
        evt = '0;
        repeat (5) tick();
        pulse_snap();
        read_stream("t3");
        chk("t3_sat", sv[1], 32'd15);
        chk("t3_wrap", sv[2], 32'd4);
        chk("t3_cyc_wrap", sv[0], 32'(exp_cyc % 16));
        chk("t3_ovf", {27'd0, m_ovf}, 32'b00111);
        cfg_sat = '0;

        // ---- 4: periodic reports and cfg_en pause ----
        do_reset();
        sel = 2;
        for (int k = 0; k < 3; k++) begin
            read_stream($sformatf("t4_p%0d", k));
            chk($sformatf("t4_p%0d_when", k), 32'(start_g), 32'(8 * (k + 1)));
            chk($sformatf("t4_p%0d_cyc", k), sv[0], 32'(8 * k + 7));
        end
        cfg_en = 1'b0;
        repeat (5) tick();
        cfg_en = 1'b1;
        read_stream("t4_p3");
        chk("t4_p3_when", 32'(start_g), 32'd37);
        chk("t4_p3_cyc", sv[0], 32'd31);
        chk("t4_no_drop", {31'd0, m_drop}, 32'd0);

        // ---- 5: back-pressure, dropped trigger, restart on last handshake ----
        do_reset();
        sel = 0;
        out_ready = 1'b0;
        repeat (3) tick();
        pulse_snap();
        for (int i = 0; i < 10; i++) begin
            snap_req = (i == 4);
            tick();
            if (i == 2) chk("t5_hold_early", a_data, 32'd3);
        end
        snap_req = 1'b0;
        chk("t5_hold_vidx", {28'd0, a_valid, a_idx}, {28'd0, 1'b1, 3'd0});
        chk("t5_hold_data", a_data, 32'd3);
        chk("t5_drop", {31'd0, a_drop}, 32'd1);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("t5_at_last", {27'd0, a_valid, a_last, a_idx}, {27'd0, 1'b1, 1'b1, 3'd4});
        pulse_snap();
        chk("t5_restart_vidx", {28'd0, a_valid, a_idx}, {28'd0, 1'b1, 3'd0});
        chk("t5_restart_data", a_data, 32'(exp_cyc));
        read_stream("t5b");
        chk("t5b_cyc", sv[0], 32'(exp_cyc));
        chk("t5_drop_sticky", {31'd0, a_drop}, 32'd1);

        // ---- 6: clear with snapshot, reset mid-stream ----
        do_reset();
        sel = 0;
        evt = 4'b0001;
        repeat (6) tick();
        evt = '0;
        repeat (4) tick();
        exp_cyc  = ncyc;
        clear    = 1'b1;
        snap_req = 1'b1;
        tick();
        clear    = 1'b0;
        snap_req = 1'b0;
        chk("t6_live_cyc", dut_a.r_cyc_cnt, 32'd0);
        chk("t6_live_evt0", dut_a.g_chan[0].u_chan.r_cnt, 32'd0);
        chk("t6_pre_cyc", a_data, 32'(exp_cyc));
        tick();
        chk("t6_pre_evt0", a_data, 32'd6);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_vidx", {27'd0, a_valid, a_last, a_idx}, 32'd0);
        chk("t6_rst_data", a_data, 32'd0);
        chk("t6_rst_state", 32'(dut_a.r_state), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
